// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI address-channel burst generator.
package axi_burst_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int unsigned AXI_4K_BYTES = 4096;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned LEN_W        = 8;
    localparam int unsigned BEATS_W      = 16;
    localparam int unsigned CALC_LEN_W   = 9;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DONE_ST
    } state_e;

    // Address-channel command held stable while AXVALID is high.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } ax_cmd_t;

endpackage

// File: rtl/axi_burst_gen_if.sv
// Request and AXI address-channel signals of the burst generator.
interface axi_burst_gen_if;

    logic        REQ_VALID;
    logic        REQ_READY;
    logic [31:0] REQ_ADDR;
    logic [15:0] REQ_BEATS;
    logic        AXVALID;
    logic        AXREADY;
    logic [31:0] AXADDR;
    logic [7:0]  AXLEN;
    logic [2:0]  AXSIZE;
    logic [1:0]  AXBURST;
    logic        BUSY;
    logic        DONE;

    // Generator side: takes requests, drives the address channel.
    modport master (
        input  REQ_VALID, REQ_ADDR, REQ_BEATS, AXREADY,
        output REQ_READY, AXVALID, AXADDR, AXLEN, AXSIZE, AXBURST, BUSY, DONE
    );

    // Requester / address-channel consumer side.
    modport slave (
        output REQ_VALID, REQ_ADDR, REQ_BEATS, AXREADY,
        input  REQ_READY, AXVALID, AXADDR, AXLEN, AXSIZE, AXBURST, BUSY, DONE
    );

endinterface

// File: rtl/axi_burst_len_calc.sv
// Length of the next INCR burst: min(remaining beats, max burst, beats left in 4 KB page).
module axi_burst_len_calc
    import axi_burst_pkg::*;
#(
    parameter int unsigned p_size      = 4,
    parameter int unsigned p_max_beats = 256
) (
    input  logic [11:0]           addr_lo,
    input  logic [BEATS_W-1:0]    rem,
    output logic [CALC_LEN_W-1:0] len_c
);

    localparam logic [12:0]        PAGE_BYTES = 13'(AXI_4K_BYTES);
    localparam logic [BEATS_W-1:0] MAX_BEATS  = BEATS_W'(p_max_beats);

    logic [12:0]        to4k;
    logic [BEATS_W-1:0] lim;

    // 13-bit page distance so a page-aligned address yields a full page.
    always_comb begin
        to4k = (PAGE_BYTES - {1'b0, addr_lo}) >> p_size;
        lim  = (rem < MAX_BEATS) ? rem : MAX_BEATS;
        if (BEATS_W'(to4k) < lim) begin
            lim = BEATS_W'(to4k);
        end
        len_c = CALC_LEN_W'(lim);
    end

endmodule

// File: rtl/axi_burst_gen.sv
// Splits a linear transfer request into 4 KB-safe AXI INCR address bursts.
module axi_burst_gen
    import axi_burst_pkg::*;
#(
    parameter int unsigned p_size      = 4,
    parameter int unsigned p_max_beats = 256
) (
    input  logic            CLK,
    input  logic            RESETn,
    axi_burst_gen_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << p_size) - ADDR_W'(1));

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BEATS_W-1:0]   rem_q, rem_d;
    ax_cmd_t              ax_q, ax_d;
    logic                 axvalid_q, axvalid_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CALC_LEN_W-1:0] len_c;
    logic [CALC_LEN_W-1:0] issued_len_c;

    axi_burst_len_calc #(
        .p_size      (p_size),
        .p_max_beats (p_max_beats)
    ) u_len_calc (
        .addr_lo (addr_q[11:0]),
        .rem     (rem_q),
        .len_c   (len_c)
    );

    // Beat count of the burst currently on the bus, recovered from AXLEN.
    assign issued_len_c = {1'b0, ax_q.len} + CALC_LEN_W'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        ax_d    = ax_q;

        case (state_q)
            IDLE: begin
                if (bus.REQ_VALID && req_ready_q) begin
                    addr_d  = bus.REQ_ADDR & ADDR_MASK;
                    rem_d   = bus.REQ_BEATS;
                    state_d = (bus.REQ_BEATS == '0) ? DONE_ST : CALC;
                end
            end
            CALC: begin
                ax_d.addr = addr_q;
                ax_d.len  = LEN_W'(len_c - CALC_LEN_W'(1));
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (axvalid_q && bus.AXREADY) begin
                    addr_d  = addr_q + (ADDR_W'(issued_len_c) << p_size);
                    rem_d   = rem_q - BEATS_W'(issued_len_c);
                    state_d = (rem_d == '0) ? DONE_ST : CALC;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        axvalid_d   = (state_d == ISSUE);
        done_d      = (state_d == DONE_ST);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            ax_q        <= '0;
            axvalid_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            ax_q        <= ax_d;
            axvalid_q   <= axvalid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.REQ_READY = req_ready_q;
    assign bus.AXVALID   = axvalid_q;
    assign bus.AXADDR    = ax_q.addr;
    assign bus.AXLEN     = ax_q.len;
    assign bus.AXSIZE    = 3'(p_size);
    assign bus.AXBURST   = BURST_INCR;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_axi_burst_gen.sv
// Randomised self-checking bench for axi_burst_gen against a burst-splitting model.
module tb_axi_burst_gen;

    logic        clk;
    logic        rst_n;
    logic        req_valid16, req_valid256;
    logic [31:0] req_addr;
    logic [15:0] req_beats;
    logic        axready;
    logic        sel;

    int total;
    int bad;

    logic [31:0] exp_a[$];
    logic [7:0]  exp_l[$];

    axi_burst_gen_if if16();
    axi_burst_gen_if if256();

    assign if16.REQ_VALID  = req_valid16;
    assign if16.REQ_ADDR   = req_addr;
    assign if16.REQ_BEATS  = req_beats;
    assign if16.AXREADY    = axready;
    assign if256.REQ_VALID = req_valid256;
    assign if256.REQ_ADDR  = req_addr;
    assign if256.REQ_BEATS = req_beats;
    assign if256.AXREADY   = axready;

    axi_burst_gen #(.p_size(4), .p_max_beats(16)) dut16 (
        .CLK(clk), .RESETn(rst_n), .bus(if16.master)
    );
    axi_burst_gen #(.p_size(4), .p_max_beats(256)) dut256 (
        .CLK(clk), .RESETn(rst_n), .bus(if256.master)
    );

    logic        o_rdy, o_axvalid, o_busy, o_done;
    logic [31:0] o_addr;
    logic [7:0]  o_len;
    logic [2:0]  o_size;
    logic [1:0]  o_burst;

    assign o_rdy     = sel ? if256.REQ_READY : if16.REQ_READY;
    assign o_axvalid = sel ? if256.AXVALID   : if16.AXVALID;
    assign o_busy    = sel ? if256.BUSY      : if16.BUSY;
    assign o_done    = sel ? if256.DONE      : if16.DONE;
    assign o_addr    = sel ? if256.AXADDR    : if16.AXADDR;
    assign o_len     = sel ? if256.AXLEN     : if16.AXLEN;
    assign o_size    = sel ? if256.AXSIZE    : if16.AXSIZE;
    assign o_burst   = sel ? if256.AXBURST   : if16.AXBURST;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bursts: walk the transfer, clipping each burst to max length and page end.
    function automatic void build_model(input logic [31:0] a, input int beats, input int maxb);
        longint unsigned ad;
        int rem, to4k, l;
        exp_a.delete();
        exp_l.delete();
        ad  = {32'd0, a & 32'hFFFF_FFF0};
        rem = beats;
        while (rem > 0) begin
            to4k = int'((64'd4096 - (ad % 64'd4096)) / 64'd16);
            l = rem;
            if (maxb < l) l = maxb;
            if (to4k < l) l = to4k;
            exp_a.push_back(ad[31:0]);
            exp_l.push_back(8'(l - 1));
            ad  = (ad + 64'(l) * 64'd16) % 64'h1_0000_0000;
            rem = rem - l;
        end
    endfunction

    task automatic drive_valid(input logic v);
        if (sel) req_valid256 = v;
        else     req_valid16  = v;
    endtask

    // Issue one request and follow it cycle by cycle to DONE; stall<0 means random stalls.
    task automatic do_request(input logic [31:0] a, input int beats, input int stall,
                              input bit hold_ready, input bit poke_busy);
        int n, st;
        total++;
        if ({o_rdy, o_busy} !== 2'b10) begin
            bad++;
            $display("FAIL idle_before_req got rdy/busy=%b want 10", {o_rdy, o_busy});
        end
        req_addr  = a;
        req_beats = 16'(beats);
        axready   = hold_ready;
        drive_valid(1'b1);
        @(posedge clk); #1;
        drive_valid(1'b0);
        build_model(a, beats, sel ? 256 : 16);
        if (beats == 0) begin
            total++;
            if ({o_done, o_axvalid, o_busy} !== 3'b101) begin
                bad++;
                $display("FAIL zero_done got done/axvalid/busy=%b want 101", {o_done, o_axvalid, o_busy});
            end
            @(posedge clk); #1;
            total++;
            if ({o_done, o_rdy, o_busy, o_axvalid} !== 4'b0100) begin
                bad++;
                $display("FAIL zero_ready_back got done/rdy/busy/axvalid=%b want 0100", {o_done, o_rdy, o_busy, o_axvalid});
            end
            axready = 1'b0;
            return;
        end
        n = exp_a.size();
        for (int b = 0; b < n; b++) begin
            total++;
            if ({o_axvalid, o_busy, o_done} !== 3'b010) begin
                bad++;
                $display("FAIL calc_bubble[%0d] got axvalid/busy/done=%b want 010", b, {o_axvalid, o_busy, o_done});
            end
            @(posedge clk); #1;
            total++;
            if ({o_axvalid, o_addr, o_len, o_size, o_burst} !== {1'b1, exp_a[b], exp_l[b], 3'd4, 2'b01}) begin
                bad++;
                $display("FAIL burst[%0d] got v=%b addr=%h len=%0d size=%0d burst=%0d want v=1 addr=%h len=%0d size=4 burst=1",
                         b, o_axvalid, o_addr, o_len, o_size, o_burst, exp_a[b], exp_l[b]);
            end
            st = hold_ready ? 0 : ((stall < 0) ? int'($urandom_range(0, 3)) : stall);
            if (!hold_ready) axready = 1'b0;
            for (int s = 0; s < st; s++) begin
                if (poke_busy && s == 0) drive_valid(1'b1);
                @(posedge clk); #1;
                drive_valid(1'b0);
                total++;
                if ({o_axvalid, o_addr, o_len, o_rdy} !== {1'b1, exp_a[b], exp_l[b], 1'b0}) begin
                    bad++;
                    $display("FAIL stall_hold[%0d] got v=%b addr=%h len=%0d rdy=%b want v=1 addr=%h len=%0d rdy=0",
                             b, o_axvalid, o_addr, o_len, o_rdy, exp_a[b], exp_l[b]);
                end
            end
            axready = 1'b1;
            @(posedge clk); #1;
            if (!hold_ready) axready = 1'b0;
        end
        total++;
        if ({o_done, o_axvalid, o_busy} !== 3'b101) begin
            bad++;
            $display("FAIL done_pulse got done/axvalid/busy=%b want 101", {o_done, o_axvalid, o_busy});
        end
        @(posedge clk); #1;
        axready = 1'b0;
        total++;
        if ({o_done, o_rdy, o_busy, o_axvalid} !== 4'b0100) begin
            bad++;
            $display("FAIL ready_back got done/rdy/busy/axvalid=%b want 0100", {o_done, o_rdy, o_busy, o_axvalid});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({if16.REQ_READY, if16.AXVALID, if16.BUSY, if16.DONE, if16.AXADDR, if16.AXLEN, if16.AXSIZE, if16.AXBURST}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 3'd4, 2'b01}) begin
            bad++;
            $display("FAIL reset16 got rdy=%b v=%b busy=%b done=%b addr=%h len=%0d size=%0d burst=%0d want 1 0 0 0 0 0 4 1",
                     if16.REQ_READY, if16.AXVALID, if16.BUSY, if16.DONE, if16.AXADDR, if16.AXLEN, if16.AXSIZE, if16.AXBURST);
        end
        total++;
        if ({if256.REQ_READY, if256.AXVALID, if256.BUSY, if256.DONE, if256.AXADDR, if256.AXLEN, if256.AXSIZE, if256.AXBURST}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 3'd4, 2'b01}) begin
            bad++;
            $display("FAIL reset256 got rdy=%b v=%b busy=%b done=%b addr=%h len=%0d size=%0d burst=%0d want 1 0 0 0 0 0 4 1",
                     if256.REQ_READY, if256.AXVALID, if256.BUSY, if256.DONE, if256.AXADDR, if256.AXLEN, if256.AXSIZE, if256.AXBURST);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        sel = 1'b0;
        do_request(32'h0000_1000, 16, 1, 1'b0, 1'b0);
    endtask

    task automatic test_multi_ready_high();
        sel = 1'b0;
        do_request(32'h0000_1000, 40, 0, 1'b1, 1'b0);
    endtask

    task automatic test_4k_clip();
        sel = 1'b0;
        do_request(32'h0000_1FC0, 8, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_and_busy_req();
        sel = 1'b0;
        do_request(32'h0000_2000, 20, 5, 1'b0, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({o_busy, o_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL busy_req_ignored got busy/rdy=%b want 01", {o_busy, o_rdy});
        end
    endtask

    task automatic test_zero_beats();
        sel = 1'b0;
        do_request(32'h0000_1234, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_max256();
        sel = 1'b1;
        do_request(32'h0000_0000, 300, -1, 1'b0, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_top_of_space();
        sel = 1'b0;
        do_request(32'hFFFF_FFC0, 8, -1, 1'b0, 1'b0);
        do_request(32'h0000_1FCF, 6, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int beats;
        for (int i = 0; i < 30; i++) begin
            sel = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = {20'($urandom), 12'hF00 | 12'($urandom_range(0, 255))};
                2:       a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
                default: a = 32'($urandom_range(0, 8191));
            endcase
            beats = (sel && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 70));
            do_request(a, beats, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        sel = 1'b0;
        req_addr  = 32'h0000_5000;
        req_beats = 16'd16;
        axready   = 1'b0;
        req_valid16 = 1'b1;
        @(posedge clk); #1;
        req_valid16 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (o_axvalid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid got axvalid=%b want 1", o_axvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({o_axvalid, o_busy, o_done, o_rdy, o_addr, o_len} !== {4'b0001, 32'h0, 8'h0}) begin
            bad++;
            $display("FAIL async_reset got v=%b busy=%b done=%b rdy=%b addr=%h len=%0d want 0 0 0 1 0 0",
                     o_axvalid, o_busy, o_done, o_rdy, o_addr, o_len);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_request(32'h0000_3000, 4, 0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        sel = 1'b0;
        rst_n = 1'b0;
        req_valid16 = 1'b0;
        req_valid256 = 1'b0;
        req_addr = '0;
        req_beats = '0;
        axready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_multi_ready_high();
        test_4k_clip();
        test_stall_and_busy_req();
        test_zero_beats();
        test_max256();
        test_top_of_space();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
